// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: write-port, B-result handshake and hazard-check signals; slave = arbiter, master = driver
interface gpr_wb_arbiter_if;
  logic a_we;
  logic [4:0] a_addr;
  logic [31:0] a_data;
  logic b_issue;
  logic [4:0] b_issue_addr;
  logic b_valid;
  logic [4:0] b_addr;
  logic [31:0] b_data;
  logic b_ready;
  logic RegWrite;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  logic [4:0] chk_addr1;
  logic [4:0] chk_addr2;
  logic busy1;
  logic busy2;
  logic sb_err;
  modport slave(
    input a_we, a_addr, a_data, b_issue, b_issue_addr, b_valid, b_addr, b_data, chk_addr1, chk_addr2,
    output b_ready, RegWrite, wr_addr, wr_data, busy1, busy2, sb_err
  );
  modport master(
    output a_we, a_addr, a_data, b_issue, b_issue_addr, b_valid, b_addr, b_data, chk_addr1, chk_addr2,
    input b_ready, RegWrite, wr_addr, wr_data, busy1, busy2, sb_err
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the GPR write port between A writeback (priority) and FIFO-buffered B results, with a pending-register scoreboard; ports clk, rst_n (async active-low), bus (gpr_wb_arbiter_if.slave)
module gpr_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  gpr_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [4:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [31:0] pending;
  logic a_req, pop, push, set_v, sb_err;
  logic [4:0] head_addr;
  logic [31:0] head_data, set_mask, clr_mask;
  always_comb begin
    a_req = rst_n && bus.a_we && bus.a_addr != 5'd0;
    pop = !a_req && count != '0;
    push = bus.b_valid && count != FULL && bus.b_addr != 5'd0;
    set_v = bus.b_issue && bus.b_issue_addr != 5'd0;
    head_addr = fifo_addr[rd_ptr];
    head_data = fifo_data[rd_ptr];
    set_mask = set_v ? 32'd1 << bus.b_issue_addr : 32'd0;
    clr_mask = pop ? 32'd1 << head_addr : 32'd0;
    bus.b_ready = count != FULL;
    bus.RegWrite = a_req || pop;
    bus.wr_addr = a_req ? bus.a_addr : pop ? head_addr : 5'd0;
    bus.wr_data = a_req ? bus.a_data : pop ? head_data : 32'd0;
    bus.busy1 = bus.chk_addr1 != 5'd0 && pending[bus.chk_addr1];
    bus.busy2 = bus.chk_addr2 != 5'd0 && pending[bus.chk_addr2];
    bus.sb_err = sb_err;
  end
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr[wr_ptr] <= bus.b_addr;
      fifo_data[wr_ptr] <= bus.b_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      pending <= '0;
      sb_err <= 1'b0;
    end else begin
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      pending <= (pending & ~clr_mask) | set_mask;
      sb_err <= sb_err
        | (set_v && pending[bus.b_issue_addr] && !clr_mask[bus.b_issue_addr])
        | (a_req && pending[bus.a_addr])
        | (pop && !pending[head_addr]);
    end
endmodule
